// File: rtl/regfile_writeback_if.sv
// Load-result handshake between the load unit (master) and the register-file write-back driver (slave).
interface regfile_writeback_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [3:0]            ld_rd;
  logic [DATA_WIDTH-1:0] ld_value;

  modport master (output ld_valid, output ld_rd, output ld_value, input ld_ready);
  modport slave  (input ld_valid, input ld_rd, input ld_value, output ld_ready);
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port driver: ALU results with priority, buffered load results, pending-load scoreboard.
// Optional WB_STATS_EN adds fifo_level, wb_count and stall_count observation ports.
module regfile_writeback #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGS_COUNT    = 16,
  parameter int LD_FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [3:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_value,
  regfile_writeback_if.slave    ld,
  input  logic                  issue_valid,
  input  logic [3:0]            issue_rd,
  output logic                  issue_ready,
  input  logic [3:0]            query_a,
  input  logic [3:0]            query_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  wb_enable,
  output logic [3:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_value,
  output logic                  err
`ifdef WB_STATS_EN
  ,
  output logic [$clog2(LD_FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                    wb_count,
  output logic [15:0]                    stall_count
`endif
);

  localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]            fifo_rd_r  [LD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_val_r [LD_FIFO_DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [REGS_COUNT-1:0] pending_r;
  logic [REGS_COUNT-1:0] pending_nxt_s;

  logic                  wb_enable_r;
  logic [3:0]            wb_rd_r;
  logic [DATA_WIDTH-1:0] wb_value_r;
  logic                  err_r;

  logic full_s;
  logic empty_s;
  logic ld_xfer_s;
  logic push_s;
  logic alu_take_s;
  logic pop_s;
  logic issue_set_s;
  logic violation_s;
  logic [3:0] head_rd_s;

  // Handshake, arbitration and hazard decode from current state
  always_comb begin
    full_s      = (count_r == CNT_W'(LD_FIFO_DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    ld.ld_ready = !full_s && !reset;
    ld_xfer_s   = ld.ld_valid && ld.ld_ready;
    push_s      = ld_xfer_s && (ld.ld_rd != 4'd0);
    alu_take_s  = alu_valid && (alu_rd != 4'd0);
    // Loads only reach the port in cycles the ALU leaves free
    pop_s       = !alu_take_s && !empty_s;
    head_rd_s   = fifo_rd_r[head_r];
    issue_ready = !pending_r[issue_rd] && !reset;
    issue_set_s = issue_valid && issue_ready;
    hazard_a    = pending_r[query_a] && (query_a != 4'd0);
    hazard_b    = pending_r[query_b] && (query_b != 4'd0);
    violation_s = (issue_valid && pending_r[issue_rd])
                || (alu_valid && pending_r[alu_rd])
                || (ld_xfer_s && (ld.ld_rd != 4'd0) && !pending_r[ld.ld_rd]);
  end

  // Next occupancy and scoreboard; an issue set overrides a same-cycle pop clear
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
    pending_nxt_s = pending_r;
    if (pop_s) begin
      pending_nxt_s[head_rd_s] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_set_s) begin
      pending_nxt_s[issue_rd] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // FIFO storage; entries past the occupancy count are don't-care
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_rd_r[tail_r]  <= ld.ld_rd;
      fifo_val_r[tail_r] <= ld.ld_value;
    end
  end

  // Pointers, occupancy, scoreboard and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      pending_r <= {REGS_COUNT{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (push_s) tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      count_r   <= count_nxt_s;
      pending_r <= pending_nxt_s;
      err_r     <= err_r || violation_s;
    end
  end

  // Write-back registers; rd/value hold when nothing is written
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_enable_r <= 1'b0;
      wb_rd_r     <= 4'd0;
      wb_value_r  <= {DATA_WIDTH{1'b0}};
    end else if (alu_take_s) begin
      wb_enable_r <= 1'b1;
      wb_rd_r     <= alu_rd;
      wb_value_r  <= alu_value;
    end else if (pop_s) begin
      wb_enable_r <= 1'b1;
      wb_rd_r     <= head_rd_s;
      wb_value_r  <= fifo_val_r[head_r];
    end else begin
      wb_enable_r <= 1'b0;
    end
  end

  assign wb_enable = wb_enable_r;
  assign wb_rd     = wb_rd_r;
  assign wb_value  = wb_value_r;
  assign err       = err_r;

`ifdef WB_STATS_EN
  logic [15:0] wb_count_r;
  logic [15:0] stall_count_r;

  // Saturating activity counters
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_count_r    <= 16'd0;
      stall_count_r <= 16'd0;
    end else begin
      if (wb_enable_r && (wb_count_r != 16'hFFFF)) begin
        wb_count_r <= wb_count_r + 16'd1;
      end
      if (alu_take_s && !empty_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
    end
  end

  assign fifo_level  = count_r;
  assign wb_count    = wb_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_value;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_ready;
  logic [3:0]  query_a;
  logic [3:0]  query_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        wb_enable;
  logic [3:0]  wb_rd;
  logic [15:0] wb_value;
  logic        err;
`ifdef WB_STATS_EN
  logic [2:0]  fifo_level;
  logic [15:0] wb_count;
  logic [15:0] stall_count;
`endif

  int checks_r;
  int errors_r;

  regfile_writeback_if #(.DATA_WIDTH(16)) ld_if ();

  regfile_writeback #(
    .DATA_WIDTH(16), .REGS_COUNT(16), .LD_FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
    .ld(ld_if.slave),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .query_a(query_a), .query_b(query_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_value(wb_value), .err(err)
`ifdef WB_STATS_EN
    , .fifo_level(fifo_level), .wb_count(wb_count), .stall_count(stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 4'd0; alu_value = 16'h0000;
    ld_if.ld_valid = 1'b0; ld_if.ld_rd = 4'd0; ld_if.ld_value = 16'h0000;
    issue_valid = 1'b0; issue_rd = 4'd0; query_a = 4'd0; query_b = 4'd0;

    // Reset state
    tick();
    check_eq("rst_ld_ready", ld_if.ld_ready, 32'd0);
    check_eq("rst_issue_ready", issue_ready, 32'd0);
    check_eq("rst_wb_enable", wb_enable, 32'd0);
    check_eq("rst_wb_rd", wb_rd, 32'd0);
    check_eq("rst_wb_value", wb_value, 32'd0);
    check_eq("rst_err", err, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ld_ready", ld_if.ld_ready, 32'd1);

    // ALU write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 4'd3; alu_value = 16'h1234;
    tick();
    alu_valid = 1'b0;
    check_eq("alu_wb_enable", wb_enable, 32'd1);
    check_eq("alu_wb_rd", wb_rd, 32'd3);
    check_eq("alu_wb_value", wb_value, 32'h1234);
    tick();
    check_eq("alu_idle_enable", wb_enable, 32'd0);
    check_eq("alu_idle_rd_hold", wb_rd, 32'd3);

    // Issue rd 5 then its load
    issue_valid = 1'b1; issue_rd = 4'd5;
    #1;
    check_eq("issue5_ready", issue_ready, 32'd1);
    tick();
    issue_valid = 1'b0; query_a = 4'd5; query_b = 4'd6;
    #1;
    check_eq("hazard_a_5", hazard_a, 32'd1);
    check_eq("hazard_b_6", hazard_b, 32'd0);
    check_eq("issue5_blocked", issue_ready, 32'd0);
    ld_if.ld_valid = 1'b1; ld_if.ld_rd = 4'd5; ld_if.ld_value = 16'hBEEF;
    #1;
    check_eq("ld5_ready", ld_if.ld_ready, 32'd1);
    tick();
    ld_if.ld_valid = 1'b0;
    check_eq("ld5_push_no_wb", wb_enable, 32'd0);
    check_eq("ld5_still_pending", hazard_a, 32'd1);
    tick();
    check_eq("ld5_wb_enable", wb_enable, 32'd1);
    check_eq("ld5_wb_rd", wb_rd, 32'd5);
    check_eq("ld5_wb_value", wb_value, 32'hBEEF);
    check_eq("ld5_cleared", hazard_a, 32'd0);
    check_eq("ld5_err", err, 32'd0);

    // Fill FIFO behind ALU traffic, then drain in order
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_rd = 4'(i);
      tick();
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd9;
    for (int i = 0; i < 6; i++) begin
      alu_value = 16'h5000 + 16'(i);
      if (i < 4) begin
        ld_if.ld_valid = 1'b1; ld_if.ld_rd = 4'(i + 1); ld_if.ld_value = 16'hA001 + 16'(i);
      end else begin
        ld_if.ld_valid = 1'b0;
      end
      tick();
      check_eq("fill_alu_value", wb_value, 32'h5000 + 32'(i));
      if (i == 3) check_eq("fill_full_ready", ld_if.ld_ready, 32'd0);
    end
    alu_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq("drain_enable", wb_enable, 32'd1);
      check_eq("drain_rd", wb_rd, 32'(j + 1));
      check_eq("drain_value", wb_value, 32'hA001 + 32'(j));
    end
    tick();
    query_a = 4'd4;
    #1;
    check_eq("drain_done", wb_enable, 32'd0);
    check_eq("drain_ready", ld_if.ld_ready, 32'd1);
    check_eq("drain_hazard4", hazard_a, 32'd0);
    check_eq("drain_err", err, 32'd0);

    // Register 0 handling
    alu_valid = 1'b1; alu_rd = 4'd0; alu_value = 16'hDEAD;
    tick();
    alu_valid = 1'b0;
    check_eq("r0_alu_dropped", wb_enable, 32'd0);
    ld_if.ld_valid = 1'b1; ld_if.ld_rd = 4'd0; ld_if.ld_value = 16'hCAFE;
    #1;
    check_eq("r0_ld_ready", ld_if.ld_ready, 32'd1);
    tick();
    ld_if.ld_valid = 1'b0;
    tick();
    check_eq("r0_ld_no_wb", wb_enable, 32'd0);
    issue_valid = 1'b1; issue_rd = 4'd0;
    tick();
    issue_valid = 1'b0; query_a = 4'd0;
    #1;
    check_eq("r0_no_hazard", hazard_a, 32'd0);
    check_eq("r0_err", err, 32'd0);

    // Reset discards buffered loads
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_rd = 4'(i);
      tick();
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd9;
    for (int i = 0; i < 3; i++) begin
      alu_value = 16'h6000 + 16'(i);
      ld_if.ld_valid = 1'b1; ld_if.ld_rd = 4'(i + 1); ld_if.ld_value = 16'hB000 + 16'(i);
      tick();
    end
    ld_if.ld_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("midrst_ld_ready", ld_if.ld_ready, 32'd0);
    check_eq("midrst_wb_enable", wb_enable, 32'd0);
    reset = 1'b0; query_a = 4'd1; query_b = 4'd2;
    #1;
    check_eq("postrst_ld_ready", ld_if.ld_ready, 32'd1);
    check_eq("postrst_hazard1", hazard_a, 32'd0);
    check_eq("postrst_hazard2", hazard_b, 32'd0);
    tick();
    check_eq("postrst_no_wb1", wb_enable, 32'd0);
    tick();
    check_eq("postrst_no_wb2", wb_enable, 32'd0);

    // WAW violation makes err sticky
    issue_valid = 1'b1; issue_rd = 4'd7;
    tick();
    issue_valid = 1'b0;
    check_eq("waw_err_before", err, 32'd0);
    alu_valid = 1'b1; alu_rd = 4'd7; alu_value = 16'h1111;
    tick();
    check_eq("waw_err_set", err, 32'd1);
    alu_rd = 4'd2; alu_value = 16'h2222;
    tick();
    alu_valid = 1'b0;
    ld_if.ld_valid = 1'b1; ld_if.ld_rd = 4'd7; ld_if.ld_value = 16'h7777;
    tick();
    ld_if.ld_valid = 1'b0;
    tick();
    check_eq("waw_ld_wb_rd", wb_rd, 32'd7);
    check_eq("waw_err_sticky", err, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("waw_err_cleared", err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side driver for the CPU register file's single write port (reg_d_enable / reg_d / reg_d_value).
- Merges two result sources onto that port:
  - single-cycle ALU results, which have no backpressure;
  - multi-cycle load results, which use a valid/ready handshake and are buffered in a FIFO.
- Keeps a pending-load scoreboard so decode can stall on RAW and WAW hazards against outstanding loads.
- Sits between the execute/load units and the register file, next to decode.

Parameters:
- DATA_WIDTH, 16, register value width; matches the data-memory width.
- REGS_COUNT, 16, number of architectural registers; index width is 4 bits.
- LD_FIFO_DEPTH, 4, load-result buffer entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  4  ALU destination register.
- alu_value  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load FIFO can accept.
- ld_rd  in  4  load destination register.
- ld_value  in  DATA_WIDTH  load data.
- issue_valid  in  1  decode issues a load.
- issue_rd  in  4  destination of the issued load.
- issue_ready  out  1  issue permitted.
- query_a  in  4  decode source register A.
- query_b  in  4  decode source register B.
- hazard_a  out  1  query_a has a load pending.
- hazard_b  out  1  query_b has a load pending.
- wb_enable  out  1  to reg_d_enable.
- wb_rd  out  4  to reg_d.
- wb_value  out  DATA_WIDTH  to reg_d_value.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset:
  - wb_enable, wb_rd, wb_value and err clear to 0.
  - FIFO empties and all pending bits clear.
  - ld_ready and issue_ready are 0 during the reset cycle.
  - A reset mid-operation discards buffered loads without writing them back.
- Write-back outputs are registered. Each rising edge selects one write for the next cycle:
  - The ALU has priority: alu_valid with alu_rd != 0 at edge N gives wb_enable=1, wb_rd=alu_rd, wb_value=alu_value during cycle N+1. Latency is 1.
  - Otherwise, if the FIFO is non-empty, the head entry is popped and driven.
  - Otherwise wb_enable=0; wb_rd and wb_value hold their last values.
- Outputs stay stable for the whole cycle, so the register file's falling-edge write sees settled data.
- Register 0:
  - ALU writes to rd 0 are dropped.
  - Loads to rd 0 are handshaken but not enqueued.
  - Issues to rd 0 never set a pending bit.
- Load handshake:
  - A transfer occurs when ld_valid && ld_ready at the rising edge.
  - ld_ready = !full. Pop and push happen in the same cycle, but ld_ready does not look ahead at a pop.
  - Pointers wrap modulo LD_FIFO_DEPTH. An occupancy count of LD_FIFO_DEPTH+1 states distinguishes full from empty.
- Scoreboard:
  - pending[REGS_COUNT-1:0].
  - issue_ready = !pending[issue_rd].
  - issue_valid && issue_ready sets pending[issue_rd].
  - A pending bit clears on the edge its load entry is popped to the write-back registers.
  - If an issue-set and a pop-clear hit the same rd in one cycle, the set wins.
- Hazard outputs (combinational from pending):
  - hazard_a = pending[query_a]; hazard_b = pending[query_b].
  - Register 0 never reports a hazard.
- Protocol violations set err, which stays set until reset; the block keeps operating. Violations are:
  - issue_valid while pending[issue_rd];
  - alu_valid to a register that is pending (WAW);
  - a load result to a non-pending rd != 0.
- Starvation: continuous ALU traffic may hold loads in the FIFO indefinitely. Decode guarantees bubbles while any hazard is outstanding.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined: adds three ports, all reset to 0:
  - fifo_level out, clog2(LD_FIFO_DEPTH)+1 bits, current occupancy;
  - wb_count out, 16 bits, saturating count of wb_enable cycles, holds at 16'hFFFF;
  - stall_count out, 16 bits, saturating count of cycles where the FIFO is non-empty and the ALU takes the write port.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then alu_valid with rd=3, value=16'h1234 at edge 1 -> cycle 2 drives wb_enable=1, wb_rd=3, wb_value=16'h1234; cycle 3 drives wb_enable=0.
- Issue rd=5 -> hazard on query_a=5 and issue_ready=0 for rd=5; load (5, 16'hBEEF) with no ALU traffic -> written the next cycle and pending[5] cleared.
- Issue rd 1..4, hold alu_valid for 6 cycles, push 4 loads -> ld_ready=0 after the 4th push; after ALU traffic stops, writes come out in order 1,2,3,4 on consecutive cycles.
- ALU rd=0 and load rd=0 -> no wb_enable; the load is still handshaken and err stays 0.
- Issue rd=7, then alu_valid rd=7 -> err=1 and stays 1 through later traffic until reset.
- Reset asserted with 3 loads buffered -> no writes afterwards, ld_ready=1 and no pending bits set on the first post-reset cycle.
